// File: rtl/t1_sram_1r1w_resp.sv
`default_nettype none
// ============================================================================
// Module   : t1_sram_1r1w_resp
// Brief    : Multi-group write / single-read row memory with an init sweep,
//            a pipelined read response of SRAM_DELAY cycles, sticky error
//            flags and saturating access counters.
// Revision : 1.0 - initial release
// ============================================================================
module t1_sram_1r1w_resp #(
    parameter int PHYWDTH    = 128,
    parameter int NUMSROW    = 4096,
    parameter int BITSROW    = 12,
    parameter int NUMGRPW    = 13,
    parameter int SRAM_DELAY = 1,
    parameter int BITCNT     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUMGRPW-1:0]           t1_writeA,
    input  logic [NUMGRPW*BITSROW-1:0]   t1_addrA,
    input  logic [PHYWDTH-1:0]           t1_dinA,
    input  logic [PHYWDTH-1:0]           t1_bwA,
    input  logic [NUMGRPW-1:0]           t1_readB,
    input  logic [NUMGRPW*BITSROW-1:0]   t1_addrB,
    output logic [PHYWDTH-1:0]           t1_doutB,
    output logic                         doutB_vld,
    output logic                         ready,
    output logic [3:0]                   err,
    output logic [BITCNT-1:0]            wr_cnt,
    output logic [BITCNT-1:0]            rd_cnt
);

    // Row index width actually needed to address the array; the port address
    // is wider so that out-of-range rows can be detected.
    localparam int c_ADDR_W = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;
    localparam int c_GSEL_W = (NUMGRPW > 1) ? $clog2(NUMGRPW) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST_ROW = c_ADDR_W'(NUMSROW - 1);

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [c_ADDR_W-1:0]    r_row_ptr;
    logic                   w_rdy;

    logic [PHYWDTH-1:0]     w_mem [NUMSROW];

    logic [NUMGRPW-1:0]     w_wr_ok;
    logic [NUMGRPW-1:0]     w_wr_oor;
    logic [c_ADDR_W-1:0]    w_wr_idx [NUMGRPW];
    logic                   w_wr_coll;

    logic [c_GSEL_W-1:0]    w_rd_sel;
    logic [BITSROW-1:0]     w_rd_addr;
    logic [31:0]            w_rd_ext;
    logic                   w_rd_oor;
    logic                   w_rd_acc;
    logic                   w_rd_multi;
    logic [PHYWDTH-1:0]     w_rd_data;

    logic [3:0]             r_err;
    logic [BITCNT-1:0]      r_wr_cnt;
    logic [BITCNT-1:0]      r_rd_cnt;

    logic [SRAM_DELAY-1:0]              r_pipe_vld;
    logic [SRAM_DELAY-1:0][PHYWDTH-1:0] r_pipe_dat;

    assign w_rdy = (r_state == c_ST_READY);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_INIT;
        else      r_state <= w_state_nxt;
    end

    // FSM next state: sweep every row once, then stay ready until reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT:  if (r_row_ptr == c_LAST_ROW) w_state_nxt = c_ST_READY;
            c_ST_READY: w_state_nxt = c_ST_READY;
            default:    w_state_nxt = c_ST_INIT;
        endcase
    end

    // Init sweep row pointer, restarts from row 0 on every reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_row_ptr <= '0;
        else if (r_state == c_ST_INIT) r_row_ptr <= r_row_ptr + c_ADDR_W'(1);
    end

    // Per-group write qualification
    generate
        for (genvar g = 0; g < NUMGRPW; g++) begin : g_grp
            logic [31:0] w_ext;
            assign w_ext       = 32'(t1_addrA[g*BITSROW +: BITSROW]);
            assign w_wr_oor[g] = t1_writeA[g] && (w_ext >= 32'(NUMSROW));
            assign w_wr_ok[g]  = w_rdy && t1_writeA[g] && (w_ext < 32'(NUMSROW));
            assign w_wr_idx[g] = t1_addrA[g*BITSROW +: c_ADDR_W];
        end
    endgenerate

    // Two accepted write groups hitting the same row
    always_comb begin
        w_wr_coll = 1'b0;
        for (int i = 0; i < NUMGRPW; i++) begin
            for (int j = i + 1; j < NUMGRPW; j++) begin
                if (w_wr_ok[i] && w_wr_ok[j] && (w_wr_idx[i] == w_wr_idx[j])) w_wr_coll = 1'b1;
            end
        end
    end

    // Storage: each row owns its register; all groups share data and mask so
    // several groups landing on one row still produce a single masked write.
    generate
        for (genvar r = 0; r < NUMSROW; r++) begin : g_row
            logic               w_we;
            logic [PHYWDTH-1:0] r_row;

            // Row write enable from any accepted group addressing this row
            always_comb begin
                w_we = 1'b0;
                for (int gi = 0; gi < NUMGRPW; gi++) begin
                    if (w_wr_ok[gi] && (w_wr_idx[gi] == c_ADDR_W'(r))) w_we = 1'b1;
                end
            end

            // Zero during the sweep, masked update afterwards (never reset)
            always_ff @(posedge clk) begin
                if (!w_rdy) begin
                    if (r_row_ptr == c_ADDR_W'(r)) r_row <= '0;
                end else if (w_we) begin
                    r_row <= (r_row & ~t1_bwA) | (t1_dinA & t1_bwA);
                end
            end

            assign w_mem[r] = r_row;
        end
    endgenerate

    // Lowest set read-enable bit selects the read group
    always_comb begin
        w_rd_sel = '0;
        for (int gi = NUMGRPW - 1; gi >= 0; gi--) begin
            if (t1_readB[gi]) w_rd_sel = c_GSEL_W'(gi);
        end
    end

    assign w_rd_addr  = t1_addrB[w_rd_sel*BITSROW +: BITSROW];
    assign w_rd_ext   = 32'(w_rd_addr);
    assign w_rd_oor   = (w_rd_ext >= 32'(NUMSROW));
    assign w_rd_acc   = w_rdy && (|t1_readB);
    assign w_rd_multi = |(t1_readB & (t1_readB - NUMGRPW'(1)));
    // Combinational array read sees the row before this edge's write
    assign w_rd_data  = w_rd_oor ? '0 : w_mem[w_rd_addr[c_ADDR_W-1:0]];

    // Read pipeline: valid shifts every cycle, data only moves with a valid
    // so the output stage holds its last value through idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_vld <= '0;
            r_pipe_dat <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            if (w_rd_acc) r_pipe_dat[0] <= w_rd_data;
            for (int k = 1; k < SRAM_DELAY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                if (r_pipe_vld[k-1]) r_pipe_dat[k] <= r_pipe_dat[k-1];
            end
        end
    end

    // Sticky error flags {addr_oor, multi_rd, wr_coll, not_ready}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {w_rdy && ((|w_wr_oor) || (w_rd_acc && w_rd_oor)),
                              w_rd_acc && w_rd_multi,
                              w_rdy && w_wr_coll,
                              !w_rdy && ((|t1_writeA) || (|t1_readB))};
        end
    end

    // Saturating write-cycle and read counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_rdy && (|t1_writeA) && !(&r_wr_cnt)) r_wr_cnt <= r_wr_cnt + BITCNT'(1);
            if (w_rd_acc && !(&r_rd_cnt))              r_rd_cnt <= r_rd_cnt + BITCNT'(1);
        end
    end

    assign t1_doutB  = r_pipe_dat[SRAM_DELAY-1];
    assign doutB_vld = r_pipe_vld[SRAM_DELAY-1];
    assign ready     = w_rdy;
    assign err       = r_err;
    assign wr_cnt    = r_wr_cnt;
    assign rd_cnt    = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_t1_sram_1r1w_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_t1_sram_1r1w_resp
// Brief    : Self-checking bench for t1_sram_1r1w_resp: directed vector table,
//            init / reset corner sequences and random traffic against a
//            behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t1_sram_1r1w_resp;

    localparam int W = 32;
    localparam int N = 16;
    localparam int B = 5;
    localparam int G = 5;
    localparam int D = 3;
    localparam int C = 4;
    localparam int CMAX = (1 << C) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [G-1:0]     writeA = '0;
    logic [G*B-1:0]   addrA  = '0;
    logic [W-1:0]     dinA   = '0;
    logic [W-1:0]     bwA    = '0;
    logic [G-1:0]     readB  = '0;
    logic [G*B-1:0]   addrB  = '0;
    logic [W-1:0]     doutB;
    logic             dvld;
    logic             rdy;
    logic [3:0]       errf;
    logic [C-1:0]     wcnt;
    logic [C-1:0]     rcnt;

    t1_sram_1r1w_resp #(
        .PHYWDTH(W), .NUMSROW(N), .BITSROW(B), .NUMGRPW(G), .SRAM_DELAY(D), .BITCNT(C)
    ) dut (
        .clk(clk), .rst(rst),
        .t1_writeA(writeA), .t1_addrA(addrA), .t1_dinA(dinA), .t1_bwA(bwA),
        .t1_readB(readB), .t1_addrB(addrB),
        .t1_doutB(doutB), .doutB_vld(dvld), .ready(rdy), .err(errf),
        .wr_cnt(wcnt), .rd_cnt(rcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    typedef struct { int due; logic [W-1:0] data; } rd_t;
    logic [W-1:0] m_mem [N];
    rd_t          m_q[$];
    int           m_edge = 0;
    int           m_init_edges = 0;
    logic [3:0]   m_err = '0;
    int           m_wr = 0;
    int           m_rd = 0;
    logic [W-1:0] m_dout = '0;
    logic         m_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [G*B-1:0] pk(input int g, input int row);
        logic [G*B-1:0] v;
        v = '0;
        v[g*B +: B] = B'(row);
        return v;
    endfunction

    // One clock cycle: drive, advance the model, compare after the edge
    task automatic step(input logic [G-1:0] w, input logic [G*B-1:0] aa,
                        input logic [W-1:0] din, input logic [W-1:0] bw,
                        input logic [G-1:0] r, input logic [G*B-1:0] ab);
        int a;
        int sel;
        int cnt;
        writeA = w; addrA = aa; dinA = din; bwA = bw; readB = r; addrB = ab;
        if (m_init_edges < N) begin
            if (w != '0 || r != '0) m_err[0] = 1'b1;
            m_init_edges++;
        end else begin
            if (r != '0) begin
                sel = -1; cnt = 0;
                for (int g = 0; g < G; g++) if (r[g]) begin cnt++; if (sel < 0) sel = g; end
                a = int'(ab[sel*B +: B]);
                if (cnt > 1) m_err[2] = 1'b1;
                if (a >= N) m_err[3] = 1'b1;
                m_q.push_back('{m_edge + D, (a < N) ? m_mem[a] : '0});
                if (m_rd < CMAX) m_rd++;
            end
            if (w != '0) begin
                if (m_wr < CMAX) m_wr++;
                for (int g = 0; g < G; g++) begin
                    if (w[g]) begin
                        a = int'(aa[g*B +: B]);
                        if (a >= N) m_err[3] = 1'b1;
                        else begin
                            m_mem[a] = (m_mem[a] & ~bw) | (din & bw);
                            for (int h = 0; h < g; h++)
                                if (w[h] && int'(aa[h*B +: B]) == a) m_err[1] = 1'b1;
                        end
                    end
                end
            end
        end
        @(posedge clk); #1;
        m_edge++;
        m_vld = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == m_edge) begin
            m_vld  = 1'b1;
            m_dout = m_q[0].data;
            void'(m_q.pop_front());
        end
        chk("ready", 64'(rdy), 64'(m_init_edges >= N));
        chk("doutB_vld", 64'(dvld), 64'(m_vld));
        chk("t1_doutB", 64'(doutB), 64'(m_dout));
        chk("err", 64'(errf), 64'(m_err));
        chk("wr_cnt", 64'(wcnt), 64'(m_wr));
        chk("rd_cnt", 64'(rcnt), 64'(m_rd));
    endtask

    task automatic idle();
        step('0, '0, '0, '0, '0, '0);
    endtask

    // Assert reset, check outputs clear at once, release on a falling edge
    task automatic do_reset(input int hold);
        writeA = '0; addrA = '0; dinA = '0; bwA = '0; readB = '0; addrB = '0;
        rst = 1'b0;
        #1;
        m_q.delete();
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        m_dout = '0; m_err = '0; m_wr = 0; m_rd = 0; m_init_edges = 0;
        chk("rst_ready", 64'(rdy), 64'd0);
        chk("rst_vld", 64'(dvld), 64'd0);
        chk("rst_dout", 64'(doutB), 64'd0);
        chk("rst_err", 64'(errf), 64'd0);
        chk("rst_wr_cnt", 64'(wcnt), 64'd0);
        chk("rst_rd_cnt", 64'(rcnt), 64'd0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < N + 2 && m_init_edges < N; i++) idle();
    endtask

    typedef struct {
        logic [G-1:0]   w;
        logic [G*B-1:0] aa;
        logic [W-1:0]   din;
        logic [W-1:0]   bw;
        logic [G-1:0]   r;
        logic [G*B-1:0] ab;
        logic           vld;
        logic [W-1:0]   dout;
        logic [3:0]     err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Directed vectors, read latency 3: read at row i appears after row i+2
        tbl[0]  = '{5'b00001, pk(0,1), 32'h0000_1111, 32'hFFFF_FFFF, 5'b00001, pk(0,5), 1'b0, 32'h0, 4'b0000};
        tbl[1]  = '{5'b00001, pk(0,3), 32'hFFFF_FFFF, 32'h00FF_00FF, 5'b00001, pk(0,3), 1'b0, 32'h0, 4'b0000};
        tbl[2]  = '{5'b00000, '0, '0, '0, 5'b00001, pk(0,3), 1'b1, 32'h0, 4'b0000};
        tbl[3]  = '{5'b10001, pk(0,7) | pk(4,7), 32'hA5A5_A5A5, 32'hFFFF_FFFF,
                    5'b00110, pk(1,1) | pk(2,2), 1'b1, 32'h0, 4'b0110};
        tbl[4]  = '{5'b00000, '0, '0, '0, 5'b00000, '0, 1'b1, 32'h00FF_00FF, 4'b0110};
        tbl[5]  = '{5'b00000, '0, '0, '0, 5'b01000, pk(3,7), 1'b1, 32'h0000_1111, 4'b0110};
        tbl[6]  = '{5'b00000, '0, '0, '0, 5'b00000, '0, 1'b0, 32'h0000_1111, 4'b0110};
        tbl[7]  = '{5'b00010, pk(1,16), 32'h1234_5678, 32'hFFFF_FFFF, 5'b00100, pk(2,17), 1'b1, 32'hA5A5_A5A5, 4'b1110};
        tbl[8]  = '{5'b00000, '0, '0, '0, 5'b00000, '0, 1'b0, 32'hA5A5_A5A5, 4'b1110};
        tbl[9]  = '{5'b00000, '0, '0, '0, 5'b00001, pk(0,0), 1'b1, 32'h0, 4'b1110};
        tbl[10] = '{5'b00000, '0, '0, '0, 5'b00000, '0, 1'b0, 32'h0, 4'b1110};
        tbl[11] = '{5'b00000, '0, '0, '0, 5'b00000, '0, 1'b1, 32'h0, 4'b1110};

        #2;
        // Reset release and init sweep timing
        do_reset(2);
        for (int i = 0; i < N; i++) begin
            chk("ready_before_edge", 64'(rdy), 64'd0);
            idle();
        end
        chk("ready_after_sweep", 64'(rdy), 64'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].w, tbl[i].aa, tbl[i].din, tbl[i].bw, tbl[i].r, tbl[i].ab);
            chk($sformatf("tbl%0d_vld", i), 64'(dvld), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d_dout", i), 64'(doutB), 64'(tbl[i].dout));
            chk($sformatf("tbl%0d_err", i), 64'(errf), 64'(tbl[i].err));
        end

        // Access during init is ignored and flagged; out-of-range write dropped
        do_reset(1);
        repeat (3) idle();
        step(5'b00001, pk(0,0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, pk(0,3));
        wait_ready();
        chk("init_err", 64'(errf), 64'b0001);
        step(5'b00001, pk(0,N), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00000, '0);
        chk("oor_err", 64'(errf), 64'b1001);
        step('0, '0, '0, '0, 5'b00001, pk(0,0));
        repeat (D) idle();
        chk("row0_clean", 64'(doutB), 64'd0);

        // Reset mid-sweep restarts the sweep
        do_reset(1);
        repeat (7) idle();
        do_reset(1);
        wait_ready();

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [G*B-1:0] ra;
            logic [G*B-1:0] rb;
            for (int g = 0; g < G; g++) begin
                ra[g*B +: B] = B'($urandom_range(0, N + 1));
                rb[g*B +: B] = B'($urandom_range(0, N + 1));
            end
            step(G'($urandom) & G'($urandom), ra, W'($urandom), W'($urandom),
                 G'($urandom) & G'($urandom) & G'($urandom), rb);
        end

        // Back-to-back reads, reset pulled mid-pipeline
        do_reset(1);
        wait_ready();
        for (int i = 0; i < 4; i++) step('0, '0, '0, '0, 5'b00001, pk(0, $urandom_range(0, N - 1)));
        do_reset(2);
        repeat (N + 4) idle();

        // Counters saturate and stay there
        for (int i = 0; i < 40; i++)
            step(G'($urandom) | G'(1), pk(0, $urandom_range(0, N - 1)), W'($urandom), W'($urandom),
                 G'(1 << $urandom_range(0, G - 1)), pk(0, 2) | pk(1, 3) | pk(2, 4) | pk(3, 5) | pk(4, 6));
        chk("wr_cnt_sat", 64'(wcnt), 64'(CMAX));
        chk("rd_cnt_sat", 64'(rcnt), 64'(CMAX));
        for (int i = 0; i < 5; i++) step(5'b00011, pk(0,1) | pk(1,2), '0, '0, 5'b00001, pk(0,1));
        chk("wr_cnt_hold", 64'(wcnt), 64'(CMAX));
        chk("rd_cnt_hold", 64'(rcnt), 64'(CMAX));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t1_sram_1r1w_resp.md
T1_SRAM_1R1W_RESP -- requirements
Module: t1_sram_1r1w_resp

Interface
REQ-001 SHALL have parameter PHYWDTH, default 128, physical row width in bits.
REQ-002 SHALL have parameter NUMSROW, default 4096, number of physical rows.
REQ-003 SHALL have parameter BITSROW, default 12, row address width.
REQ-004 SHALL have parameter NUMGRPW, default 13, number of write/read command groups.
REQ-005 SHALL have parameter SRAM_DELAY, default 1 (legal 1..4), read latency in cycles.
REQ-006 SHALL have parameter BITCNT, default 16, statistics counter width.
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port t1_writeA  input  NUMGRPW  per-group write enable.
REQ-010 SHALL have port t1_addrA  input  NUMGRPW*BITSROW  per-group write row, group g at [g*BITSROW +: BITSROW].
REQ-011 SHALL have port t1_dinA  input  PHYWDTH  write data shared by all groups.
REQ-012 SHALL have port t1_bwA  input  PHYWDTH  bit write mask, 1 = write bit.
REQ-013 SHALL have port t1_readB  input  NUMGRPW  per-group read enable.
REQ-014 SHALL have port t1_addrB  input  NUMGRPW*BITSROW  per-group read row.
REQ-015 SHALL have port t1_doutB  output  PHYWDTH  read data.
REQ-016 SHALL have port doutB_vld  output  1  t1_doutB carries data of a read issued SRAM_DELAY cycles earlier.
REQ-017 SHALL have port ready  output  1  initialisation complete.
REQ-018 SHALL have port err  output  4  sticky flags {addr_oor, multi_rd, wr_coll, not_ready}.
REQ-019 SHALL have ports wr_cnt, rd_cnt  output  BITCNT each  accepted write-cycle / read counters.

Function
REQ-020 SHALL implement FSM INIT -> READY; reset enters INIT with row pointer 0.
REQ-021 In INIT SHALL write all-zero to row pointer each cycle and increment it; after row NUMSROW-1 is written SHALL enter READY next cycle; ready = 1 exactly in READY (first high NUMSROW cycles after rst deasserts).
REQ-022 In INIT any asserted t1_writeA/t1_readB bit SHALL be ignored and SHALL set err[0].
REQ-023 In READY, for each g with t1_writeA[g] and addrA[g] < NUMSROW, bits of row addrA[g] where t1_bwA=1 SHALL take t1_dinA; other bits unchanged; all groups write in the same cycle.
REQ-024 Two or more write groups addressing the same row in one cycle SHALL set err[1]; stored result is the single masked write (data is shared, so deterministic).
REQ-025 In READY, if exactly one t1_readB[g] is set, row addrB[g] SHALL be read; if several are set the lowest index g SHALL be used and err[2] set.
REQ-026 Read and write to the same row in the same cycle SHALL return pre-write (old) data.
REQ-027 Read data SHALL appear on t1_doutB with doutB_vld=1 exactly SRAM_DELAY cycles after the read cycle; fully pipelined, one read per cycle sustained.
REQ-028 Cycles with no read in the pipeline output stage SHALL drive doutB_vld=0 and hold t1_doutB at its previous value.
REQ-029 Any accepted address >= NUMSROW SHALL set err[3]; such a write is dropped, such a read returns all-zero with doutB_vld=1.
REQ-030 wr_cnt SHALL increment by 1 per READY cycle with any t1_writeA bit set; rd_cnt by 1 per accepted read; both saturate at all-ones (no wrap).
REQ-031 err bits SHALL be sticky until reset; multiple bits may set in one cycle.

Reset
REQ-032 rst=0 SHALL immediately force ready=0, doutB_vld=0, t1_doutB=0, err=0, wr_cnt=0, rd_cnt=0, FSM=INIT, row pointer 0, and discard in-flight reads.
REQ-033 Memory array SHALL not be reset asynchronously; contents are defined only by the INIT sweep, which restarts on every reset including mid-sweep.

Verification
REQ-034 Reset release, NUMSROW=16 -> ready rises on 16th cycle; read row 5 -> t1_doutB=0, doutB_vld high SRAM_DELAY cycles later.
REQ-035 Write row 3 din=all-ones, bwA=0x00FF..., then read row 3 -> low 8 bits per byte-lane pattern match mask, others 0; same-cycle read of row 3 during write -> 0.
REQ-036 Groups 0 and 4 write row 7 same cycle, readB bits 1 and 2 set (rows 1, 2) -> err=4'b0110, row 1 data returned.
REQ-037 readB asserted during INIT and addrA=NUMSROW in READY -> err[0]=1, err[3]=1, row content unchanged, read of OOR row returns 0.
REQ-038 Back-to-back reads with SRAM_DELAY=3, rst pulled low mid-pipeline -> doutB_vld=0 at once, no stale data after release; counters at all-ones stay all-ones on further traffic.
